beep_alarm_ctrl: RTL and testbench



---
 rtl/beep_alarm_if.sv | 22 ++
 rtl/beep_alarm_ctrl.sv | 173 +++++++++++++++++
 tb/tb_beep_alarm_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/beep_alarm_if.sv
// Signal bundle between the ranging/control side and beep_alarm_ctrl.
interface beep_alarm_if #(
    parameter int unsigned DIST_W = 16
) ();
    logic              en;
    logic              dist_vld;
    logic [DIST_W-1:0] dist_cm;
    logic              manual_req;
    logic [1:0]        beep_flag;
    logic [1:0]        zone;
    logic              stale;

    modport master (
        output en, dist_vld, dist_cm, manual_req,
        input  beep_flag, zone, stale
    );

    modport slave (
        input  en, dist_vld, dist_cm, manual_req,
        output beep_flag, zone, stale
    );
endinterface

// File: rtl/beep_alarm_ctrl.sv
// Distance-to-alarm controller: hysteresis, confirmed/held downgrades,
// stale-sample silencing and a timed manual beep override.
module beep_alarm_ctrl #(
    parameter int unsigned DIST_W     = 16,
    parameter int unsigned NEAR_CM    = 20,
    parameter int unsigned FAR_CM     = 50,
    parameter int unsigned HYST_CM    = 5,
    parameter int unsigned CONFIRM    = 3,
    parameter int unsigned HOLD_CYC   = 25_000_000,
    parameter int unsigned STALE_CYC  = 50_000_000,
    parameter int unsigned MANUAL_CYC = 100_000_000
) (
    input  logic         Clk,
    input  logic         Rst_n,
    beep_alarm_if.slave  bus
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int unsigned STALE_W = (STALE_CYC > 1) ? $clog2(STALE_CYC) : 1;
    localparam int unsigned MAN_W   = $clog2(MANUAL_CYC + 1);

    localparam logic [DIST_W:0]    NEAR_HYST = (DIST_W+1)'(NEAR_CM + HYST_CM);
    localparam logic [DIST_W:0]    FAR_HYST  = (DIST_W+1)'(FAR_CM + HYST_CM);
    localparam logic [CNT_W-1:0]   CONF_MAX  = CNT_W'(CONFIRM);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYC - 1);
    localparam logic [MAN_W-1:0]   MAN_LOAD  = MAN_W'(MANUAL_CYC);

    // Encoding is ordered by severity so a plain compare detects upgrades.
    typedef enum logic [1:0] {
        Z_SAFE   = 2'b00,
        Z_WARN   = 2'b01,
        Z_DANGER = 2'b10
    } zone_t;

    zone_t               zone_q, zone_nxt, raw_cls, dn_tgt;
    logic [CNT_W-1:0]    confirm_q, confirm_nxt, confirm_inc;
    logic [HOLD_W-1:0]   hold_q, hold_nxt;
    logic [STALE_W-1:0]  stale_cnt_q, stale_cnt_nxt;
    logic                stale_q, stale_nxt;
    logic [MAN_W-1:0]    manual_q, manual_nxt;
    logic [1:0]          beep_q, beep_nxt;
    logic                dn_req, is_zero, far_dn, hold_done;
    logic [DIST_W:0]     d_ext;

    // Classify the current sample and derive the downgrade request/target.
    always_comb begin
        d_ext   = {1'b0, bus.dist_cm};
        is_zero = (bus.dist_cm == '0);
        far_dn  = is_zero || (d_ext >= FAR_HYST);
        raw_cls = Z_SAFE;
        if (!is_zero && (bus.dist_cm < DIST_W'(NEAR_CM))) begin
            raw_cls = Z_DANGER;
        end else if (!is_zero && (bus.dist_cm < DIST_W'(FAR_CM))) begin
            raw_cls = Z_WARN;
        end
        dn_req = 1'b0;
        dn_tgt = Z_SAFE;
        case (zone_q)
            Z_DANGER: begin
                dn_req = is_zero || (d_ext >= NEAR_HYST);
                dn_tgt = far_dn ? Z_SAFE : Z_WARN;
            end
            Z_WARN:  dn_req = far_dn;
            default: dn_req = 1'b0;
        endcase
        hold_done   = (hold_q == HOLD_MAX);
        confirm_inc = (confirm_q >= CONF_MAX) ? CONF_MAX : confirm_q + CNT_W'(1);
    end

    // Zone state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            zone_q <= Z_SAFE;
        end else begin
            zone_q <= zone_nxt;
        end
    end

    // Next-state: zone transitions plus confirm, hold, stale and manual timers.
    always_comb begin
        zone_nxt      = zone_q;
        confirm_nxt   = confirm_q;
        hold_nxt      = hold_q;
        stale_cnt_nxt = stale_cnt_q;
        stale_nxt     = stale_q;
        manual_nxt    = manual_q;
        if (!bus.en) begin
            zone_nxt      = Z_SAFE;
            confirm_nxt   = '0;
            hold_nxt      = '0;
            stale_cnt_nxt = '0;
            stale_nxt     = 1'b0;
            manual_nxt    = '0;
        end else begin
            if (bus.manual_req) begin
                manual_nxt = MAN_LOAD;
            end else if (manual_q != '0) begin
                manual_nxt = manual_q - MAN_W'(1);
            end
            if (!hold_done) begin
                hold_nxt = hold_q + HOLD_W'(1);
            end
            if (bus.dist_vld) begin
                stale_cnt_nxt = '0;
                stale_nxt     = 1'b0;
                if (raw_cls > zone_q) begin
                    zone_nxt = raw_cls;
                end else if (dn_req) begin
                    if ((confirm_inc == CONF_MAX) && hold_done) begin
                        zone_nxt = dn_tgt;
                    end else begin
                        confirm_nxt = confirm_inc;
                    end
                end else begin
                    confirm_nxt = '0;
                end
            end else if (stale_cnt_q == STALE_MAX) begin
                zone_nxt    = Z_SAFE;
                stale_nxt   = 1'b1;
                confirm_nxt = '0;
            end else begin
                stale_cnt_nxt = stale_cnt_q + STALE_W'(1);
            end
            // Any zone change restarts both the hold timer and the confirm count.
            if (zone_nxt != zone_q) begin
                hold_nxt    = '0;
                confirm_nxt = '0;
            end
        end
    end

    // Buzzer command from the next-state values so it lines up with zone.
    always_comb begin
        beep_nxt = 2'b00;
        if (!bus.en) begin
            beep_nxt = 2'b00;
        end else if (manual_nxt != '0) begin
            beep_nxt = 2'b10;
        end else begin
            case (zone_nxt)
                Z_DANGER: beep_nxt = 2'b10;
                Z_WARN:   beep_nxt = 2'b01;
                default:  beep_nxt = 2'b00;
            endcase
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            confirm_q   <= '0;
            hold_q      <= '0;
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
            manual_q    <= '0;
            beep_q      <= 2'b00;
        end else begin
            confirm_q   <= confirm_nxt;
            hold_q      <= hold_nxt;
            stale_cnt_q <= stale_cnt_nxt;
            stale_q     <= stale_nxt;
            manual_q    <= manual_nxt;
            beep_q      <= beep_nxt;
        end
    end

    assign bus.zone      = zone_q;
    assign bus.beep_flag = beep_q;
    assign bus.stale     = stale_q;

endmodule

// File: tb/tb_beep_alarm_ctrl.sv
// Directed bench for beep_alarm_ctrl with shortened timing parameters.
module tb_beep_alarm_ctrl;

    logic Clk;
    logic Rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cnt;

    beep_alarm_if #(.DIST_W(16)) bus ();

    beep_alarm_ctrl #(
        .DIST_W(16), .NEAR_CM(20), .FAR_CM(50), .HYST_CM(5), .CONFIRM(3),
        .HOLD_CYC(8), .STALE_CYC(32), .MANUAL_CYC(16)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        vld;
        logic [15:0] d;
        logic [1:0]  zone;
        logic [1:0]  beep;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic vld, input logic [15:0] d,
                                input logic [1:0] z, input logic [1:0] b);
        vec_t v;
        v.vld = vld; v.d = d; v.zone = z; v.beep = b;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [1:0] z,
                              input logic [1:0] b, input logic s);
        check({name, ".zone"},  bus.zone,  z);
        check({name, ".beep"},  bus.beep_flag, b);
        check({name, ".stale"}, {1'b0, bus.stale}, {1'b0, s});
    endtask

    // One clock with the given inputs, strobes dropped afterwards.
    task automatic step(input logic vld, input logic [15:0] d, input logic man);
        bus.dist_vld   = vld;
        bus.dist_cm    = d;
        bus.manual_req = man;
        @(posedge Clk);
        #1;
        bus.dist_vld   = 1'b0;
        bus.manual_req = 1'b0;
    endtask

    initial begin
        Rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.dist_vld   = 1'b0;
        bus.dist_cm    = '0;
        bus.manual_req = 1'b0;
        #2;
        check_outs("reset", 2'b00, 2'b00, 1'b0);
        #10;
        Rst_n = 1'b1;

        // Danger entry, held/confirmed downgrade, hysteresis, class boundaries.
        add(1, 15, 2'b10, 2'b10);
        add(0, 0,  2'b10, 2'b10);
        add(1, 30, 2'b10, 2'b10);
        add(0, 0,  2'b10, 2'b10);
        add(1, 30, 2'b10, 2'b10);
        add(0, 0,  2'b10, 2'b10);
        add(1, 30, 2'b10, 2'b10);
        add(0, 0,  2'b10, 2'b10);
        add(1, 30, 2'b01, 2'b01);
        for (int i = 0; i < 8; i++) add(1, 16'(52 + (i % 3)), 2'b01, 2'b01);
        add(1, 55, 2'b01, 2'b01);
        add(1, 55, 2'b01, 2'b01);
        add(1, 55, 2'b00, 2'b00);
        add(1, 50, 2'b00, 2'b00);
        add(1, 0,  2'b00, 2'b00);
        add(1, 20, 2'b01, 2'b01);
        add(1, 19, 2'b10, 2'b10);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vld, tbl[i].d, 1'b0);
            check_outs($sformatf("vec%0d", i), tbl[i].zone, tbl[i].beep, 1'b0);
        end

        // Confirm counter cleared by an intervening non-downgrade sample.
        for (int i = 0; i < 8; i++) step(0, 0, 0);
        step(1, 60, 0); check("conf_a", bus.zone, 2'b10);
        step(1, 60, 0); check("conf_b", bus.zone, 2'b10);
        step(1, 10, 0); check("conf_c", bus.zone, 2'b10);
        step(1, 60, 0); check("conf_d", bus.zone, 2'b10);
        step(1, 60, 0); check("conf_e", bus.zone, 2'b10);
        for (int i = 0; i < 3; i++) step(1, 60, 0);
        check_outs("conf_end", 2'b00, 2'b00, 1'b0);

        // Stale expiry after 32 idle cycles, then recovery on the next sample.
        step(1, 10, 0);
        for (int i = 0; i < 31; i++) step(0, 0, 0);
        check_outs("stale_pre", 2'b10, 2'b10, 1'b0);
        step(0, 0, 0);
        check_outs("stale_hit", 2'b00, 2'b00, 1'b1);
        step(1, 40, 0);
        check_outs("stale_clr", 2'b01, 2'b01, 1'b0);

        // A sample landing on the expiry cycle wins.
        for (int i = 0; i < 31; i++) step(0, 0, 0);
        step(1, 15, 0);
        check_outs("stale_race", 2'b10, 2'b10, 1'b0);

        // Clear via enable, then single and retriggered manual override.
        bus.en = 1'b0;
        step(0, 0, 0);
        check_outs("en_clr", 2'b00, 2'b00, 1'b0);
        bus.en = 1'b1;
        step(0, 0, 1);
        cnt = 0;
        while (cnt < 40 && bus.beep_flag == 2'b10) begin
            cnt++;
            step(0, 0, 0);
        end
        total++;
        if (cnt != 16) begin
            bad++;
            $display("FAIL manual_len: got %0d want 16", cnt);
        end
        check("manual_off", bus.beep_flag, 2'b00);

        step(0, 0, 1);
        cnt = 0;
        while (cnt < 60 && bus.beep_flag == 2'b10) begin
            cnt++;
            step(0, 0, cnt == 10);
        end
        total++;
        if (cnt != 26) begin
            bad++;
            $display("FAIL retrig_len: got %0d want 26", cnt);
        end

        // Enable drop during danger with override active; manual ignored while disabled.
        step(1, 10, 0);
        step(0, 0, 1);
        check_outs("pre_en", 2'b10, 2'b10, 1'b0);
        bus.en = 1'b0;
        step(0, 0, 0);
        check_outs("en_off", 2'b00, 2'b00, 1'b0);
        step(0, 0, 1);
        check_outs("en_man", 2'b00, 2'b00, 1'b0);
        bus.en = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        check_outs("en_back", 2'b00, 2'b00, 1'b0);
        step(1, 10, 0);
        check_outs("en_samp", 2'b10, 2'b10, 1'b0);

        // Asynchronous reset mid-cycle with override active.
        step(0, 0, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        check_outs("async_rst", 2'b00, 2'b00, 1'b0);
        @(posedge Clk);
        #3;
        Rst_n = 1'b1;
        step(0, 0, 0);
        check_outs("post_rst", 2'b00, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
